rx_word_align_ctrl: RTL

Receive-side word aligner for the 8:1 geared differential lanes driven by the PF_IOD transmit path. It sits in the fabric clock domain between a receive IOD's 8-bit RX_DATA bus and the user logic. After a start request it searches for a fixed training word. It issues single-cycle RX_BIT_SLIP pulses to the IOD until the word is seen for a programmable number of consecutive cycles, then reports lock (or failure) and forwards registered aligned data.

---
 rtl/rx_word_align_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rx_word_align_ctrl.sv
// Receive word aligner for 8:1 geared IOD lanes: searches for a training word,
// pulses RX_BIT_SLIP until it is stable, then reports lock/fail.
//
// Ports:
//   FAB_CLK, ARST_N        fabric clock, async active-low reset
//   ALIGN_START            one-cycle (re)start request, accepted in any state
//   RX_DATA_0[7:0]         deserialised word from the receive IOD
//   RX_BIT_SLIP            registered one-cycle slip pulse to the IOD
//   ALIGN_BUSY/DONE/FAIL   search in progress / locked / gave up
//   BIT_SLIP_CNT[3:0]      slips issued since the last start
//   RX_DATA_ALIGNED[7:0]   RX_DATA_0 delayed one cycle
//   RX_DATA_ALIGNED_VALID  high while locked
module rx_word_align_ctrl #(
    parameter logic [7:0]  TRAIN_PATTERN = 8'hB8,
    parameter int unsigned MATCH_COUNT   = 16,
    parameter int unsigned SLIP_WAIT     = 8,
    parameter int unsigned MAX_SLIPS     = 7
) (
    input  logic       FAB_CLK,
    input  logic       ARST_N,
    input  logic       ALIGN_START,
    input  logic [7:0] RX_DATA_0,
    output logic       RX_BIT_SLIP,
    output logic       ALIGN_BUSY,
    output logic       ALIGN_DONE,
    output logic       ALIGN_FAIL,
    output logic [3:0] BIT_SLIP_CNT,
    output logic [7:0] RX_DATA_ALIGNED,
    output logic       RX_DATA_ALIGNED_VALID
);

    localparam logic [7:0] MATCH_TGT = 8'(MATCH_COUNT);
    localparam logic [7:0] WAIT_LAST = 8'(SLIP_WAIT - 1);
    localparam logic [3:0] SLIP_MAX  = 4'(MAX_SLIPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SLIP,
        S_WAIT,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] match_cnt;
    logic [7:0] match_nx;
    logic [7:0] match_inc;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nx;
    logic [3:0] slip_cnt;
    logic [3:0] slip_nx;
    logic       slip_q;
    logic [7:0] data_q;

    // Saturating increment of the run-length counter.
    assign match_inc = (match_cnt == 8'hFF) ? match_cnt : match_cnt + 8'd1;

    always_comb begin
        state_nx = state;
        match_nx = match_cnt;
        wait_nx  = wait_cnt;
        slip_nx  = slip_cnt;
        if (ALIGN_START) begin
            state_nx = S_CHECK;
            match_nx = 8'd0;
            wait_nx  = 8'd0;
            slip_nx  = 4'd0;
        end else begin
            unique case (state)
                S_CHECK: begin
                    if (RX_DATA_0 == TRAIN_PATTERN) begin
                        match_nx = match_inc;
                        if (match_inc == MATCH_TGT) begin
                            state_nx = S_LOCKED;
                        end
                    end else if (slip_cnt < SLIP_MAX) begin
                        match_nx = 8'd0;
                        slip_nx  = slip_cnt + 4'd1;
                        state_nx = S_SLIP;
                    end else begin
                        state_nx = S_FAIL;
                    end
                end
                S_SLIP: begin
                    wait_nx  = 8'd0;
                    state_nx = S_WAIT;
                end
                S_WAIT: begin
                    // IOD output is unreliable while it re-gears after a slip.
                    if (wait_cnt == WAIT_LAST) begin
                        wait_nx  = 8'd0;
                        match_nx = 8'd0;
                        state_nx = S_CHECK;
                    end else begin
                        wait_nx = wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state_nx = state;
                end
            endcase
        end
    end

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state     <= S_IDLE;
            match_cnt <= 8'd0;
            wait_cnt  <= 8'd0;
            slip_cnt  <= 4'd0;
            slip_q    <= 1'b0;
            data_q    <= 8'd0;
        end else begin
            state     <= state_nx;
            match_cnt <= match_nx;
            wait_cnt  <= wait_nx;
            slip_cnt  <= slip_nx;
            // A start always lands in CHECK, so it also squashes the pulse.
            slip_q    <= (state_nx == S_SLIP);
            data_q    <= RX_DATA_0;
        end
    end

    assign RX_BIT_SLIP           = slip_q;
    assign ALIGN_BUSY            = (state == S_CHECK) ||
                                   (state == S_SLIP)  ||
                                   (state == S_WAIT);
    assign ALIGN_DONE            = (state == S_LOCKED);
    assign ALIGN_FAIL            = (state == S_FAIL);
    assign BIT_SLIP_CNT          = slip_cnt;
    assign RX_DATA_ALIGNED       = data_q;
    assign RX_DATA_ALIGNED_VALID = (state == S_LOCKED);

endmodule
